// File: rtl/l1_mem_pkg.sv
// Shared types and constants for the L1 memory responder.
package l1_mem_pkg;

    localparam int DATA_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int DEFAULT_LATENCY = 4;
    // Wide enough for the largest supported countdown (LATENCY-1 = 14).
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Request fields latched at capture; compared against the live
    // request to flag protocol violations.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/l1_mem_ram.sv
// Single-port word array: synchronous write, combinational read.
module l1_mem_ram
    import l1_mem_pkg::*;
#(
    parameter  int WORDS = 4096,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];

    // Write port: commit the word on the clock edge.
    // NOTE: the array has no reset on purpose; contents must survive rst and a
    // reset loop over thousands of words would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/l1_mem_responder.sv
// Fixed-latency memory responder: captures one request, answers after
// LATENCY cycles, then holds one cycle before accepting the next.
module l1_mem_responder
    import l1_mem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_we,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_resp_valid,
    output logic [DATA_W-1:0] mem_resp_rdata,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              proto_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [31:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]        wr_cnt_q, wr_cnt_d;
    logic               err_q, err_d;

    logic               capture;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [DATA_W-1:0]  ram_rdata;
    logic               in_flight;
    logic               req_differs;

    // A request is taken only from IDLE; HOLD deliberately ignores valid.
    assign capture     = (state_q == ST_IDLE) && mem_req_valid;
    // Writes commit at the capture edge so later requests see them.
    assign ram_we      = capture && mem_req_we;
    // Byte offset and bits above the index are dropped, so addresses alias.
    assign ram_idx     = capture ? mem_req_addr[IDX_W+1:2] : req_q.addr[IDX_W+1:2];
    assign in_flight   = (state_q == ST_WAIT) || (state_q == ST_RESP);
    assign req_differs = !mem_req_valid
                      || (mem_req_we    != req_q.we)
                      || (mem_req_addr  != req_q.addr)
                      || (mem_req_wdata != req_q.wdata);

    l1_mem_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (mem_req_wdata),
        .rdata (ram_rdata)
    );

    // State and datapath registers; reset abandons any pending response.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: WAIT counts down so RESP lands LATENCY cycles after capture.
    // NOTE: defaults at the top of each always_comb keep every path assigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture, completion counters and sticky error.
    always_comb begin
        req_d    = req_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        if (capture) begin
            req_d = '{we: mem_req_we, addr: mem_req_addr, wdata: mem_req_wdata};
        end
        if (state_q == ST_RESP) begin
            if (req_q.we) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
        // A violation is only flagged; the transaction completes with captured values.
        if (in_flight && req_differs) begin
            err_d = 1'b1;
        end
    end

    // Outputs: response pulse and read data only while in RESP.
    always_comb begin
        mem_resp_valid = (state_q == ST_RESP);
        mem_resp_rdata = '0;
        if ((state_q == ST_RESP) && !req_q.we) begin
            mem_resp_rdata = ram_rdata;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench: LATENCY=4 responder for timing, aliasing, protocol error
// and reset cases; a LATENCY=1 responder for the minimum-latency turnaround.
module tb_l1_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata, rd_cnt, wr_cnt;
    logic        perr;

    logic        req_valid1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic        resp_valid1;
    logic [31:0] resp_rdata1, rd_cnt1, wr_cnt1;
    logic        perr1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    l1_mem_responder #(.MEM_WORDS(4096), .LATENCY(LAT)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (req_valid),
        .mem_req_we     (req_we),
        .mem_req_addr   (req_addr),
        .mem_req_wdata  (req_wdata),
        .mem_resp_valid (resp_valid),
        .mem_resp_rdata (resp_rdata),
        .rd_count       (rd_cnt),
        .wr_count       (wr_cnt),
        .proto_err      (perr)
    );

    l1_mem_responder #(.MEM_WORDS(16), .LATENCY(1)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (req_valid1),
        .mem_req_we     (req_we1),
        .mem_req_addr   (req_addr1),
        .mem_req_wdata  (req_wdata1),
        .mem_resp_valid (resp_valid1),
        .mem_resp_rdata (resp_rdata1),
        .rd_count       (rd_cnt1),
        .wr_count       (wr_cnt1),
        .proto_err      (perr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=4 responder. Called at a negedge in IDLE;
    // returns at the negedge of the following IDLE cycle. pos is the index of
    // the negedge (after the capture edge) where the pulse was seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int chg_at, input logic [31:0] chg_addr,
                          output int pos, output int pulses,
                          output logic [31:0] rdata, output int cap_edge);
        pos = 0; pulses = 0; rdata = 'x; cap_edge = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) cap_edge = edge_cnt;
            if (k == chg_at) req_addr = chg_addr;
            if (resp_valid) begin
                pulses++;
                if (pos == 0) begin
                    pos   = k;
                    rdata = resp_rdata;
                end
            end
            if (pos != 0 && k == pos + 1) req_valid = 1'b0;
            if (pos != 0 && k == pos + 2) break;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pos, pulses, cap, p1, p2, cnt;
        logic [31:0] rd, d1, d2;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_rd_count", rd_cnt, 32'h0);
        check("rst_wr_count", wr_cnt, 32'h0);
        check("rst_proto_err", {31'b0, perr}, 32'h0);
        rst = 1'b0;

        // Write 0x40 <= DEADBEEF captured at edge 10, response in cycle 14
        while (edge_cnt != 9) @(negedge clk);
        do_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, pos, pulses, rd, cap);
        check("wr_capture_edge", cap, 32'd10);
        check("wr_resp_cycle", cap + pos, 32'd14);
        check("wr_pulses", pulses, 32'd1);
        check("wr_rdata_zero", rd, 32'h0);
        check("wr_count_1", wr_cnt, 32'd1);
        check("rd_count_0", rd_cnt, 32'd0);

        do_req(1'b1, 32'h0000_0044, 32'h1234_5678, 0, 32'h0, pos, pulses, rd, cap);
        check("wr2_count", wr_cnt, 32'd2);

        // Read back and aliased read (bit 16 and byte offset ignored)
        do_req(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, pos, pulses, rd, cap);
        check("rd_pos", pos, LAT);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_count_1", rd_cnt, 32'd1);
        do_req(1'b0, 32'h0001_0040, 32'h0, 0, 32'h0, pos, pulses, rd, cap);
        check("rd_alias_hi", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0001_0043, 32'h0, 0, 32'h0, pos, pulses, rd, cap);
        check("rd_alias_lo", rd, 32'hDEAD_BEEF);
        check("rd_count_3", rd_cnt, 32'd3);
        check("proto_clean", {31'b0, perr}, 32'h0);

        // Valid held across two reads: spacing LAT+2, no capture in HOLD
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_wdata = '0;
        p1 = 0; p2 = 0; cnt = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 2 * LAT + 3; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                cnt++;
                if (p1 == 0) begin p1 = k; d1 = resp_rdata; end
                else if (p2 == 0) begin p2 = k; d2 = resp_rdata; end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_first", p1, LAT);
        check("b2b_spacing", p2 - p1, LAT + 2);
        check("b2b_pulses", cnt, 32'd2);
        check("b2b_data1", d1, 32'h1234_5678);
        check("b2b_data2", d2, 32'h1234_5678);
        check("b2b_rd_count", rd_cnt, 32'd5);

        // Address changed during WAIT: error flagged, captured word returned
        do_req(1'b0, 32'h0000_0040, 32'h0, 2, 32'h0000_0044, pos, pulses, rd, cap);
        check("perr_pos", pos, LAT);
        check("perr_data", rd, 32'hDEAD_BEEF);
        check("perr_set", {31'b0, perr}, 32'h1);
        do_req(1'b0, 32'h0000_0044, 32'h0, 0, 32'h0, pos, pulses, rd, cap);
        check("perr_clean_data", rd, 32'h1234_5678);
        check("perr_sticky", {31'b0, perr}, 32'h1);
        check("rd_count_7", rd_cnt, 32'd7);

        // Reset two cycles after capture of a read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_resp", {31'b0, resp_valid}, 32'h0);
        check("mid_rst_rd_count", rd_cnt, 32'd0);
        check("mid_rst_wr_count", wr_cnt, 32'd0);
        check("mid_rst_perr", {31'b0, perr}, 32'h0);
        rst = 1'b0;
        // Request in the first cycle after release is captured normally
        do_req(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, pos, pulses, rd, cap);
        check("post_rst_pos", pos, LAT);
        check("post_rst_pulses", pulses, 32'd1);
        check("post_rst_data", rd, 32'hDEAD_BEEF);
        check("post_rst_rd_count", rd_cnt, 32'd1);

        // LATENCY=1 responder: write, then two held reads
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h80; req_wdata1 = 32'hA5A5_0001;
        @(negedge clk);
        check("l1_wr_resp", {31'b0, resp_valid1}, 32'h1);
        @(negedge clk);
        req_valid1 = 1'b0;
        @(negedge clk);
        req_valid1 = 1'b1; req_we1 = 1'b0; req_wdata1 = '0;
        p1 = 0; p2 = 0; cnt = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (resp_valid1) begin
                cnt++;
                if (p1 == 0) begin p1 = k; d1 = resp_rdata1; end
                else if (p2 == 0) begin p2 = k; d2 = resp_rdata1; end
            end
        end
        req_valid1 = 1'b0;
        @(negedge clk);
        check("l1_first_pos", p1, 32'd1);
        check("l1_next_pos", p2, 32'd4);
        check("l1_pulses", cnt, 32'd2);
        check("l1_data1", d1, 32'hA5A5_0001);
        check("l1_data2", d2, 32'hA5A5_0001);
        check("l1_rd_count", rd_cnt1, 32'd2);
        check("l1_wr_count", wr_cnt1, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_mem_responder.md
L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, 4096, number of 32-bit backing words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, 4, cycles from request capture to response (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_req_valid  input  1  initiator request, level-held until response.
REQ-006 SHALL have port mem_req_we  input  1  1 = word write, 0 = word read.
REQ-007 SHALL have port mem_req_addr  input  32  byte address; word index = addr[log2(MEM_WORDS)+1:2].
REQ-008 SHALL have port mem_req_wdata  input  32  write data (full word, no strobes).
REQ-009 SHALL have port mem_resp_valid  output  1  one-cycle response/ack pulse.
REQ-010 SHALL have port mem_resp_rdata  output  32  read data, valid only with mem_resp_valid.
REQ-011 SHALL have port rd_count  output  32  completed reads.
REQ-012 SHALL have port wr_count  output  32  completed writes.
REQ-013 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> HOLD -> IDLE.
REQ-015 In IDLE with mem_req_valid=1 at edge T, SHALL capture we/addr/wdata, load countdown LATENCY-1, go to WAIT (LATENCY=1: go directly to RESP).
REQ-016 WAIT SHALL decrement countdown each cycle; at zero go to RESP.
REQ-017 mem_resp_valid SHALL be 1 only in RESP, exactly one cycle, in cycle T+LATENCY after capture edge T.
REQ-018 A captured write SHALL commit to the word array on the capture edge; the word is read-visible to any later request.
REQ-019 For reads, mem_resp_rdata SHALL equal the array word at the captured index during RESP; otherwise 32'h0.
REQ-020 For writes, mem_resp_rdata SHALL be 32'h0 during RESP.
REQ-021 HOLD SHALL last one cycle and ignore mem_req_valid, so the initiator can drop valid; earliest next capture is edge T+LATENCY+2.
REQ-022 Address bits above the index and bits [1:0] SHALL be ignored (aliasing wrap, no error).
REQ-023 rd_count/wr_count SHALL increment by 1 on the RESP cycle of a read/write; wrap 0xFFFFFFFF -> 0.
REQ-024 proto_err SHALL set if, in WAIT or RESP, mem_req_valid=0 or mem_req_we/addr/wdata differ from captured values; cleared only by rst.
REQ-025 A violation SHALL NOT abort the transaction; captured values are used.

Reset
REQ-026 On rst=1 at an edge: state IDLE, countdown 0, mem_resp_valid 0, mem_resp_rdata 0, rd_count 0, wr_count 0, proto_err 0.
REQ-027 Reset mid-transaction SHALL drop the pending response without counting it; a write already committed at capture SHALL remain in the array.
REQ-028 Word array contents SHALL NOT be reset.
REQ-029 mem_req_valid high in the first cycle after reset release SHALL be captured normally.

Structure
REQ-030 FSM state encoding, default LATENCY and the 32-bit data/address widths SHALL reside in shared package l1_mem_pkg.
REQ-031 The word array SHALL be a sub-module l1_mem_ram (single-port, synchronous write, combinational or registered read fitting REQ-019 timing).
REQ-032 Counters SHALL be local registers, not perf_counters.

Verification
REQ-033 Write 0x0000_0040 <= 0xDEADBEEF captured at edge 10, LATENCY=4 -> resp_valid only in cycle 14, rdata 0, wr_count=1.
REQ-034 Read 0x0000_0040 after REQ-033 -> rdata 0xDEADBEEF in response cycle, rd_count=1; read 0x0001_0040 (MEM_WORDS=4096) aliases -> 0xDEADBEEF.
REQ-035 valid held continuously across back-to-back reads -> responses spaced LATENCY+2 cycles, no duplicate capture during HOLD.
REQ-036 addr changed from 0x40 to 0x44 during WAIT -> proto_err=1, response still returns word 0x40, proto_err persists until rst.
REQ-037 rst asserted 2 cycles after capture of a read -> no resp_valid, rd_count=0; earlier written 0xDEADBEEF still readable after reset.
REQ-038 LATENCY=1 build: capture at edge T -> resp_valid in cycle T+1, next capture edge T+3.
